// File: rtl/mul_ctrl_if.sv
// Handshake bundle between the repeated-addition multiplier controller and its
// environment: commands in, datapath strobes and status out.
interface mul_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             abort;
    logic             eqz;
    logic             ld_a;
    logic             ld_b;
    logic             clr_p;
    logic             ld_p;
    logic             dec_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] iter_cnt;

    modport master (
        output start, abort, eqz,
        input  ld_a, ld_b, clr_p, ld_p, dec_b, busy, done, iter_cnt
    );

    modport slave (
        input  start, abort, eqz,
        output ld_a, ld_b, clr_p, ld_p, dec_b, busy, done, iter_cnt
    );
endinterface

// File: rtl/mul_ctrl.sv
// Moore controller for the repeated-addition multiplier: loads A and B, clears P,
// then alternates CHECK/ADD until B reaches zero, counting the ADD cycles.
module mul_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    mul_ctrl_if.slave ctl
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_ADD    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] iter_cnt_q, iter_cnt_d;

    // Abort wins over every other exit from a busy state; DONE always completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (ctl.start) state_d = S_LOAD_A;
            S_LOAD_A: state_d = ctl.abort ? S_IDLE : S_LOAD_B;
            S_LOAD_B: state_d = ctl.abort ? S_IDLE : S_CHECK;
            S_CHECK: begin
                if (ctl.abort)    state_d = S_IDLE;
                else if (ctl.eqz) state_d = S_DONE;
                else              state_d = S_ADD;
            end
            S_ADD:    state_d = ctl.abort ? S_IDLE : S_CHECK;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // The count updates on leaving LOAD_B/ADD whatever the next state is, so an
    // aborted ADD is still counted.
    always_comb begin
        iter_cnt_d = iter_cnt_q;
        if (state_q == S_LOAD_B) begin
            iter_cnt_d = '0;
        end else if (state_q == S_ADD && iter_cnt_q != CNT_MAX) begin
            iter_cnt_d = iter_cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            iter_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    assign ctl.ld_a     = (state_q == S_LOAD_A);
    assign ctl.ld_b     = (state_q == S_LOAD_B);
    assign ctl.clr_p    = (state_q == S_LOAD_B);
    assign ctl.ld_p     = (state_q == S_ADD);
    assign ctl.dec_b    = (state_q == S_ADD);
    assign ctl.done     = (state_q == S_DONE);
    assign ctl.busy     = (state_q != S_IDLE);
    assign ctl.iter_cnt = iter_cnt_q;
endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: drives a behavioural A/B/P datapath and checks every cycle
// against a schedule derived from the operation timing rules.
module tb_mul_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_ctrl_if #(.WIDTH(16)) bus ();
    mul_ctrl_if #(.WIDTH(2))  bus2 ();

    mul_ctrl #(.WIDTH(16)) dut  (.clk(clk), .rst_n(rst_n), .ctl(bus));
    mul_ctrl #(.WIDTH(2))  dut2 (.clk(clk), .rst_n(rst_n), .ctl(bus2));

    // Datapath: pipo registers A, B, P with B decrementer and B==0 comparator.
    logic [15:0] ra, rb, rp, a_op, b_op, din;
    assign din     = bus.ld_a ? a_op : b_op;
    assign bus.eqz = (rb == 16'd0);
    always @(posedge clk) begin
        if (bus.ld_a) ra <= din;
        if (bus.ld_b) rb <= din;
        else if (bus.dec_b) rb <= rb - 16'd1;
        if (bus.clr_p) rp <= 16'd0;
        else if (bus.ld_p) rp <= rp + ra;
    end

    logic [6:0] obs;
    assign obs = {bus.ld_a, bus.ld_b, bus.clr_p, bus.ld_p, bus.dec_b, bus.busy, bus.done};

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_iter;

    typedef struct {
        int a; int b; int ab; int smask; int hold;
        int exp_done; int exp_p; int exp_iter;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {ld_a,ld_b,clr_p,ld_p,dec_b,busy,done} in cycle c after start,
    // for B=n and abort asserted in cycle ab (0 = no abort).
    function automatic logic [6:0] exp_vec(input int c, input int n, input int ab);
        if (ab > 0 && c > ab)              return 7'b0000000;
        if (c == 1)                        return 7'b1000010;
        if (c == 2)                        return 7'b0110010;
        if (c == 3)                        return 7'b0000010;
        if (c >= 4 && c <= 3 + 2 * n)      return (c % 2 == 0) ? 7'b0001110 : 7'b0000010;
        if (c == 4 + 2 * n)                return 7'b0000011;
        return 7'b0000000;
    endfunction

    task automatic run_op(input int a, input int b, input int ab, input int smask,
                          input int hold, output int done_c);
        int last;
        logic [6:0] ev;
        logic busy_c;
        last = (ab > 0) ? ab + 1 : 5 + 2 * b;
        a_op = 16'(a);
        b_op = 16'(b);
        bus.start = 1'b1;
        bus.abort = 1'b0;
        step();
        done_c = -1;
        for (int c = 1; c <= last; c++) begin
            busy_c = (c <= 4 + 2 * b) && (ab == 0 || c <= ab);
            bus.start = (hold != 0) ? 1'b1 : (busy_c && smask[c % 32]);
            bus.abort = (c == ab);
            ev = exp_vec(c, b, ab);
            chk("cycle outputs/iter_cnt", 64'({obs, bus.iter_cnt}), 64'({ev, exp_iter}));
            if (bus.done && done_c < 0) done_c = c;
            if (ev[5]) exp_iter = 16'd0;
            else if (ev[3] && exp_iter != 16'hFFFF) exp_iter = exp_iter + 16'd1;
            if (c < last) step();
        end
        bus.abort = 1'b0;
        if (hold == 0) bus.start = 1'b0;
    endtask

    initial begin
        int dc;
        int a, b, ab, sm;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0; bus2.eqz = 1'b0;
        a_op = 16'd0; b_op = 16'd0;
        exp_iter = 16'd0;

        #2;
        chk("reset outputs", 64'({obs, bus.iter_cnt}), 64'd0);
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle after reset", 64'({obs, bus.iter_cnt}), 64'd0);

        tbl[0] = '{7, 3, 0, 0,     0, 10, 21, 3};
        tbl[1] = '{9, 0, 0, 0,     0, 4,  0,  0};
        tbl[2] = '{2, 5, 6, 0,     0, -1, 0,  2};
        tbl[3] = '{3, 2, 0, 32'h28, 0, 8,  6,  2};
        tbl[4] = '{1, 1, 0, 0,     1, 6,  1,  1};
        tbl[5] = '{4, 2, 0, 0,     0, 8,  8,  2};
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].ab, tbl[i].smask, tbl[i].hold, dc);
            chk("done cycle", 64'(dc), 64'(tbl[i].exp_done));
            if (tbl[i].ab == 0) chk("product P", 64'(rp), 64'(tbl[i].exp_p));
            chk("final iter_cnt", 64'(bus.iter_cnt), 64'(tbl[i].exp_iter));
        end

        // Asynchronous reset in the middle of an ADD.
        a_op = 16'd5; b_op = 16'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        chk("pre-reset ld_p", 64'(bus.ld_p), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", 64'({obs, bus.iter_cnt}), 64'd0);
        step();
        #2;
        rst_n = 1'b1;
        exp_iter = 16'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("idle after mid-op reset", 64'({obs, bus.iter_cnt}), 64'd0);
        end

        // Saturation on a 2-bit counter: five ADDs must stop at 3.
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        bus2.eqz = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("sat iter_cnt", 64'(bus2.iter_cnt), 64'd3);
        chk("sat busy", 64'(bus2.busy), 64'd1);
        bus2.eqz = 1'b1;
        step();
        chk("sat done", 64'({bus2.done, bus2.iter_cnt}), 64'({1'b1, 2'd3}));
        step();
        chk("sat idle", 64'(bus2.busy), 64'd0);

        // Randomized operations with stray start pulses and occasional abort.
        for (int i = 0; i < 25; i++) begin
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 12));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3 + 2 * b)) : 0;
            sm = int'($urandom);
            run_op(a, b, ab, sm, 0, dc);
            chk("rand done cycle", 64'(dc), 64'((ab > 0) ? -1 : 4 + 2 * b));
            if (ab == 0) chk("rand product P", 64'(rp), 64'(16'(a * b)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
